// File: rtl/fib_bcd_conv_if.sv
// Handshake bundle between the Fibonacci engine, the BCD converter and the
// display/report stage.
//   vld_in/rdy_in/bin_in         : binary value from the engine
//   vld_out/rdy_out/bcd_out/ndig_out : packed BCD result to the display stage
// slave  : the converter side
// master : the side that feeds values in and takes results out
interface fib_bcd_conv_if #(
  parameter int unsigned N_BIN = 32,
  parameter int unsigned N_DIG = 10
);
  localparam int unsigned BCD_W  = 4 * N_DIG;
  localparam int unsigned NDIG_W = $clog2(N_DIG + 1);

  logic              vld_in;
  logic              rdy_in;
  logic [N_BIN-1:0]  bin_in;
  logic              vld_out;
  logic              rdy_out;
  logic [BCD_W-1:0]  bcd_out;
  logic [NDIG_W-1:0] ndig_out;

  modport slave (
    input  vld_in, bin_in, rdy_out,
    output rdy_in, vld_out, bcd_out, ndig_out
  );

  modport master (
    output vld_in, bin_in, rdy_out,
    input  rdy_in, vld_out, bcd_out, ndig_out
  );
endinterface

// File: rtl/fib_bcd_conv.sv
// Binary-to-packed-BCD converter using iterative double-dabble, one input
// bit per clock. Accepts one value at a time and holds the result until the
// downstream stage takes it.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fib_bcd_conv_if.slave (vld_in/rdy_in/bin_in in,
//           vld_out/rdy_out/bcd_out/ndig_out out)
module fib_bcd_conv #(
  parameter int unsigned N_BIN = 32,
  parameter int unsigned N_DIG = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  fib_bcd_conv_if.slave   bus
);

  localparam int unsigned BCD_W  = 4 * N_DIG;
  localparam int unsigned NDIG_W = $clog2(N_DIG + 1);
  localparam int unsigned CNT_W  = $clog2(N_BIN + 1);

  // True when N_DIG decimal digits can hold every N_BIN-bit value,
  // i.e. 10^N_DIG >= 2^N_BIN (the two are never equal for N_BIN > 0).
  function automatic bit digits_ok(input int unsigned nb, input int unsigned nd);
    logic [255:0] p;
    p = 256'd1;
    for (int i = 0; i < 76; i++) begin
      if (i < int'(nd)) p = p * 256'd10;
    end
    return (p >= (256'd1 << nb));
  endfunction

  if (!digits_ok(N_BIN, N_DIG)) begin : g_bad_digits
    $error("fib_bcd_conv: N_DIG too small for N_BIN");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [N_BIN-1:0]  r_bin;
  logic [BCD_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rdy_in;
  logic              r_vld_out;
  logic [BCD_W-1:0]  r_bcd;
  logic [NDIG_W-1:0] r_ndig;

  logic [BCD_W-1:0]  w_adj;
  logic [BCD_W-1:0]  w_acc_nxt;
  logic [NDIG_W-1:0] w_ndig;
  logic              w_last;

  // Add-3 correction on every digit that would overflow past 9 when doubled.
  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < int'(N_DIG); d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
    end
  end

  // Shift corrected accumulator left, pulling in the next binary MSB;
  // the accumulator's top bit is always zero after a full conversion.
  assign w_acc_nxt = BCD_W'({w_adj, r_bin[N_BIN-1]});

  // Significant-digit count of the accumulator about to be delivered;
  // ascending scan so the highest nonzero digit wins, zero reports 1.
  always_comb begin
    w_ndig = NDIG_W'(1);
    for (int d = 0; d < int'(N_DIG); d++) begin
      if (w_acc_nxt[4*d +: 4] != 4'd0) begin
        w_ndig = NDIG_W'(d + 1);
      end
    end
  end

  assign w_last = (r_cnt == CNT_W'(N_BIN - 1));

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bin     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_rdy_in  <= 1'b0;
      r_vld_out <= 1'b0;
      r_bcd     <= '0;
      r_ndig    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rdy_in <= 1'b1;
          // rdy_in is registered, so accept only once it is visibly high.
          if (r_rdy_in && bus.vld_in) begin
            r_bin    <= bus.bin_in;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_bcd    <= '0;
            r_rdy_in <= 1'b0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc <= w_acc_nxt;
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_bcd     <= w_acc_nxt;
            r_ndig    <= w_ndig;
            r_vld_out <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (bus.rdy_out) begin
            r_vld_out <= 1'b0;
            r_rdy_in  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rdy_in   = r_rdy_in;
  assign bus.vld_out  = r_vld_out;
  assign bus.bcd_out  = r_bcd;
  assign bus.ndig_out = r_ndig;

endmodule

// File: tb/tb_fib_bcd_conv.sv
// Self-checking bench for fib_bcd_conv: transaction-level reference model
// (decimal conversion by division, handshake timing by cycle countdown)
// compared against the DUT every cycle, plus literal expectations.
module tb_fib_bcd_conv;

  localparam int unsigned N_BIN = 32;
  localparam int unsigned N_DIG = 10;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  fib_bcd_conv_if #(.N_BIN(N_BIN), .N_DIG(N_DIG)) bus ();

  fib_bcd_conv #(.N_BIN(N_BIN), .N_DIG(N_DIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  function automatic logic [39:0] to_bcd(input longint unsigned v);
    logic [39:0] r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 10; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int dec_digits(input longint unsigned v);
    int n;
    longint unsigned x;
    n = 1;
    x = v;
    while (x >= 10) begin
      x = x / 10;
      n++;
    end
    return n;
  endfunction

  logic        m_rdy;
  logic        m_vld;
  logic [39:0] m_bcd;
  int          m_ndig;
  int          m_busy;
  logic [31:0] m_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy  = 1'b0;
      m_vld  = 1'b0;
      m_bcd  = '0;
      m_ndig = 0;
      m_busy = 0;
      m_val  = '0;
    end else if (m_vld) begin
      if (bus.rdy_out) begin
        m_vld = 1'b0;
        m_rdy = 1'b1;
      end
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_vld  = 1'b1;
        m_bcd  = to_bcd(longint'(m_val));
        m_ndig = dec_digits(longint'(m_val));
      end
    end else if (m_rdy && bus.vld_in) begin
      m_rdy  = 1'b0;
      m_val  = bus.bin_in;
      m_busy = N_BIN;
      m_bcd  = '0;
    end else begin
      m_rdy = 1'b1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    chk("rdy_in",   64'(bus.rdy_in),   64'(m_rdy));
    chk("vld_out",  64'(bus.vld_out),  64'(m_vld));
    chk("bcd_out",  64'(bus.bcd_out),  64'(m_bcd));
    chk("ndig_out", 64'(bus.ndig_out), 64'(m_ndig));
  end

  // ---------------- stimulus helpers ----------------
  int acc_cyc;

  // Present v until accepted; returns at the negedge after the accept edge.
  task automatic send(input logic [31:0] v);
    int t;
    t = 0;
    bus.vld_in = 1'b1;
    bus.bin_in = v;
    while (!bus.rdy_in && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rdy_in) timeout_fail("send");
    acc_cyc = cyc;
    @(negedge clk);
    bus.vld_in = 1'b0;
    bus.bin_in = $urandom;
  endtask

  // Wait for the result, stall rdy_out for 'stall' cycles, then take it.
  task automatic get_result(input logic [39:0] exp_bcd, input int exp_nd,
                            input bit use_exp, input int stall, input bit noise);
    int t;
    int s;
    bit got;
    t = 0;
    s = stall;
    got = 1'b0;
    bus.rdy_out = 1'b0;
    while (!got && t < 200) begin
      @(negedge clk);
      t++;
      if (bus.vld_out) begin
        bus.vld_in = 1'b0;
        if (use_exp) begin
          chk("lit_bcd",  64'(bus.bcd_out),  64'(exp_bcd));
          chk("lit_ndig", 64'(bus.ndig_out), 64'(exp_nd));
          chk("lit_rdy_in_busy", 64'(bus.rdy_in), 64'd0);
        end
        if (s > 0) begin
          s--;
          bus.rdy_out = 1'b0;
        end else begin
          bus.rdy_out = 1'b1;
          got = 1'b1;
        end
      end else if (noise) begin
        bus.vld_in = 1'($urandom_range(0, 1));
        bus.bin_in = $urandom;
      end
    end
    if (!got) timeout_fail("get_result");
    @(negedge clk);
    if (use_exp) chk("lit_vld_drop", 64'(bus.vld_out), 64'd0);
    bus.rdy_out = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    int t1;
    int t;
    bit seen55;
    logic [31:0] v;

    rst_n       = 1'b0;
    bus.vld_in  = 1'b0;
    bus.bin_in  = '0;
    bus.rdy_out = 1'b0;

    // Pin the model against hand-computed values.
    chk("model_bcd_fib47", 64'(to_bcd(64'd2971215073)), 64'h2971215073);
    chk("model_bcd_max",   64'(to_bcd(64'hFFFFFFFF)),   64'h4294967295);
    chk("model_nd_zero",   64'(dec_digits(64'd0)),      64'd1);
    chk("model_nd_10",     64'(dec_digits(64'd10)),     64'd2);

    repeat (3) @(negedge clk);
    chk("rst_rdy_in",  64'(bus.rdy_in),   64'd0);
    chk("rst_vld_out", 64'(bus.vld_out),  64'd0);
    chk("rst_bcd",     64'(bus.bcd_out),  64'd0);
    chk("rst_ndig",    64'(bus.ndig_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 64'(bus.rdy_in), 64'd1);

    // Directed values.
    send(32'd0);
    t0 = acc_cyc;
    get_result(40'h0000000000, 1, 1'b1, 0, 1'b0);
    send(32'd10);          get_result(40'h0000000010, 2,  1'b1, 0, 1'b1);
    send(32'd9);           get_result(40'h0000000009, 1,  1'b1, 0, 1'b0);
    send(32'd2971215073);  get_result(40'h2971215073, 10, 1'b1, 0, 1'b1);
    send(32'hFFFFFFFF);    get_result(40'h4294967295, 10, 1'b1, 0, 1'b0);

    // Back-to-back 55, 89 with rdy_out high and vld_in noise in between.
    bus.rdy_out = 1'b1;
    send(32'd55);
    t0 = acc_cyc;
    bus.rdy_out = 1'b1;
    seen55 = 1'b0;
    t = 0;
    while (t < 100) begin
      if (bus.rdy_in) break;
      if (bus.vld_out) begin
        chk("b2b_bcd55", 64'(bus.bcd_out), 64'h55);
        seen55 = 1'b1;
      end
      bus.vld_in = 1'($urandom_range(0, 1));
      bus.bin_in = $urandom;
      @(negedge clk);
      t++;
    end
    if (!bus.rdy_in) timeout_fail("b2b_wait");
    chk("b2b_seen55", 64'(seen55), 64'd1);
    send(32'd89);
    t1 = acc_cyc;
    chk("b2b_gap", 64'(t1 - t0), 64'(N_BIN + 2));
    get_result(40'h89, 2, 1'b1, 0, 1'b0);

    // Downstream stall of 5 cycles.
    send(32'd144);
    get_result(40'h144, 3, 1'b1, 5, 1'b0);

    // Asynchronous reset in the middle of a conversion.
    send(32'd123456789);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rdy_in",  64'(bus.rdy_in),   64'd0);
    chk("midrst_vld_out", 64'(bus.vld_out),  64'd0);
    chk("midrst_bcd",     64'(bus.bcd_out),  64'd0);
    chk("midrst_ndig",    64'(bus.ndig_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    send(32'd21);
    get_result(40'h21, 2, 1'b1, 0, 1'b0);

    // Randomized values, gaps, stalls and ignored vld_in pulses.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = $urandom_range(0, 999);
        2: v = 32'($urandom_range(0, 9)) * 32'd100000;
        default: v = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(v);
      get_result(40'h0, 0, 1'b0, $urandom_range(0, 3), 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_bcd_conv.md
Name: fib_bcd_conv

Overview:
- Downstream stage of the Fibonacci engine. It consumes the engine's binary result through a valid/ready handshake.
- It converts the result to packed BCD using iterative double-dabble, one bit per cycle.
- It presents the BCD digits and a significant-digit count to the display/report stage through a second valid/ready handshake.
- Single clock domain. One conversion in flight at a time.

Parameters:
- N_BIN, 32, width of the binary input (matches the Fibonacci result width).
- N_DIG, 10, number of BCD digits produced. Must satisfy 10^N_DIG > 2^N_BIN - 1; violating this is an elaboration error.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- vld_in  input  1  upstream binary value valid.
- rdy_in  output  1  block can accept a value.
- bin_in  input  N_BIN  unsigned binary value.
- vld_out  output  1  BCD result valid.
- rdy_out  input  1  downstream accepts the result.
- bcd_out  output  4*N_DIG  packed BCD; digit 0 (units) is at [3:0].
- ndig_out  output  $clog2(N_DIG+1)  count of significant digits, range 1..N_DIG.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE and clears all datapath registers. Output values while reset is held:
  - rdy_in = 0, vld_out = 0, bcd_out = 0, ndig_out = 0.
  - rdy_in first rises in the cycle after rst_n deasserts.
- State IDLE:
  - rdy_in = 1.
  - On a rising edge with vld_in = 1: latch bin_in into the shift register, clear the BCD accumulator and bit counter, go to SHIFT.
- State SHIFT: rdy_in = 0, vld_out = 0. Each edge performs one iteration:
  - Every BCD digit >= 5 gets +3 (4-bit add, no carry between digits).
  - The accumulator then shifts left by 1, taking the binary register's MSB into bit 0.
  - The binary register shifts left by 1, and the counter increments.
  - After exactly N_BIN iterations, go to DONE.
- State DONE:
  - vld_out = 1.
  - bcd_out and ndig_out are registered and stable for as long as vld_out is high.
  - On an edge with rdy_out = 1, go to IDLE.
  - rdy_out low holds DONE indefinitely, with outputs unchanged.
- Latency: take the accept edge as edge 0. vld_out is high after edge N_BIN (33 cycles for the default). With rdy_out held high, rdy_in returns after edge N_BIN+1. Throughput is one value per N_BIN+2 cycles.
- ndig_out: index of the most significant nonzero digit + 1. A value of 0 gives ndig_out = 1. It is computed from the final accumulator on the same edge that enters DONE.
- bcd_out outside DONE: holds the last delivered result until the next accept, then is cleared. Downstream must qualify it with vld_out.
- vld_in while busy: ignored (rdy_in = 0). No capture, and the in-flight conversion is unaffected.
- Digit bounds: digits never exceed 9 in DONE.
- Reset mid-SHIFT or mid-DONE: the conversion is abandoned and nothing is emitted. The block then behaves as after power-up.
- No combinational path from vld_in to rdy_in, or from rdy_out to vld_out.

Test Plan:
- bin_in = 0 -> after 33 cycles: bcd_out = 40'h0000000000, ndig_out = 1.
- bin_in = 10 -> bcd_out = 40'h0000000010, ndig_out = 2. Also 9 -> 40'h9, ndig_out = 1.
- bin_in = 2971215073 (fib 47) -> bcd_out = 40'h2971215073, ndig_out = 10. bin_in = 32'hFFFFFFFF -> 40'h4294967295, ndig_out = 10.
- Back-to-back values 55, 89 with rdy_out tied high -> two results 40'h55 then 40'h89. Second accept occurs exactly N_BIN+2 cycles after the first. vld_in pulses in between are ignored.
- Result 144 with rdy_out held low 5 cycles -> vld_out stays high, bcd_out stays 40'h144, rdy_in stays 0. Handshake completes on the first rdy_out-high edge.
- rst_n pulsed low at iteration 12 of a conversion -> outputs 0 immediately (asynchronous). No vld_out. The next input 21 converts correctly to 40'h21.
